// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Even parity makes the total count of ones even; odd is its complement.
    function automatic logic parity_bit(input logic [UART_DATA_W-1:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational view of the head entry.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] wptr_reg;
    logic [ADDR_W-1:0] rptr_reg;
    logic [ADDR_W:0]   count_reg;

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count_reg == DEPTH);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rdata   = mem[rptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_reg] <= wdata;
        end
    end

    // Pointers wrap naturally at the depth since they are exactly ADDR_W bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (do_push) wptr_reg <= wptr_reg + ADDR_W'(1);
            if (do_pop)  rptr_reg <= rptr_reg + ADDR_W'(1);
            if (do_push && !do_pop)      count_reg <= count_reg + (ADDR_W+1)'(1);
            else if (do_pop && !do_push) count_reg <= count_reg - (ADDR_W+1)'(1);
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// Buffered UART transmitter: valid/ready byte input, FIFO, and frame serialiser.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_ADDR_W  = 3,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [UART_DATA_W-1:0] in_data,
    output logic                   in_ready,
    output logic                   tx,
    output logic                   busy,
    output logic                   tx_done,
    output logic [FIFO_ADDR_W:0]   fifo_count
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t              state_reg;
    logic [BAUD_W-1:0]      baud_reg;
    logic [2:0]             bit_idx_reg;
    logic [UART_DATA_W-1:0] shift_reg;
    logic [UART_DATA_W-1:0] data_reg;
    logic                   tx_reg;
    logic                   done_reg;

    logic [UART_DATA_W-1:0] fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   bit_end;
    logic                   stop_end;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign bit_end  = (baud_reg == BAUD_LAST);
    assign stop_end = (state_reg == ST_STOP) && bit_end && (bit_idx_reg == STOP_LAST);
    // Popping at the end of STOP chains frames with no idle gap.
    assign pop      = !fifo_empty && ((state_reg == ST_IDLE) || stop_end);

    assign tx         = tx_reg;
    assign tx_done    = done_reg;
    assign busy       = (state_reg != ST_IDLE) || (fifo_count != '0);

    sync_fifo #(
        .DATA_W(UART_DATA_W),
        .ADDR_W(FIFO_ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            data_reg    <= '0;
            tx_reg      <= 1'b1;
            done_reg    <= 1'b0;
        end else begin
            // Registered so the pulse lands in the final cycle of the last stop bit.
            done_reg <= (state_reg == ST_STOP) && (bit_idx_reg == STOP_LAST) && (baud_reg == BAUD_PRE);

            if (pop) begin
                shift_reg   <= fifo_rdata;
                data_reg    <= fifo_rdata;
                tx_reg      <= 1'b0;
                baud_reg    <= '0;
                bit_idx_reg <= '0;
                state_reg   <= ST_START;
            end else if (state_reg != ST_IDLE) begin
                if (!bit_end) begin
                    baud_reg <= baud_reg + BAUD_W'(1);
                end else begin
                    baud_reg <= '0;
                    case (state_reg)
                        ST_START: begin
                            tx_reg      <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                            bit_idx_reg <= '0;
                            state_reg   <= ST_DATA;
                        end
                        ST_DATA: begin
                            if (bit_idx_reg == 3'd7) begin
                                bit_idx_reg <= '0;
                                if (PARITY_MODE != PARITY_NONE) begin
                                    tx_reg    <= parity_bit(data_reg, PARITY_MODE);
                                    state_reg <= ST_PARITY;
                                end else begin
                                    tx_reg    <= 1'b1;
                                    state_reg <= ST_STOP;
                                end
                            end else begin
                                tx_reg      <= shift_reg[0];
                                shift_reg   <= shift_reg >> 1;
                                bit_idx_reg <= bit_idx_reg + 3'd1;
                            end
                        end
                        ST_PARITY: begin
                            tx_reg      <= 1'b1;
                            bit_idx_reg <= '0;
                            state_reg   <= ST_STOP;
                        end
                        ST_STOP: begin
                            if (bit_idx_reg != STOP_LAST) begin
                                bit_idx_reg <= bit_idx_reg + 3'd1;
                            end else begin
                                tx_reg    <= 1'b1;
                                state_reg <= ST_IDLE;
                            end
                        end
                        default: begin
                            tx_reg    <= 1'b1;
                            state_reg <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule
